// File: rtl/tlb_pkg.sv
// Shared TLB types and constants: entry layout, page sizes, invtlb op codes.
// Imported by tlb_match and tlb_multiport.
package tlb_pkg;

  localparam int LO_W   = 26;
  localparam int VPPN_W = 19;
  localparam int ASID_W = 10;
  localparam int PS_W   = 6;

  localparam logic [PS_W-1:0] PS_4K = 6'd12;
  localparam logic [PS_W-1:0] PS_4M = 6'd21;

  localparam logic [4:0] INVTLB_OP_ALL0     = 5'd0;
  localparam logic [4:0] INVTLB_OP_ALL1     = 5'd1;
  localparam logic [4:0] INVTLB_OP_G1       = 5'd2;
  localparam logic [4:0] INVTLB_OP_G0       = 5'd3;
  localparam logic [4:0] INVTLB_OP_ASID     = 5'd4;
  localparam logic [4:0] INVTLB_OP_ASID_VA  = 5'd5;
  localparam logic [4:0] INVTLB_OP_GASID_VA = 5'd6;

  typedef struct packed {
    logic              e;
    logic              g;
    logic [VPPN_W-1:0] vppn;
    logic [PS_W-1:0]   ps;
    logic [ASID_W-1:0] asid;
    logic [LO_W-1:0]   lo0;
    logic [LO_W-1:0]   lo1;
  } tlb_entry_t;

  // A 4M page covers 512 vppns, so only vppn[18:9] takes part in the compare.
  function automatic logic va_match(input tlb_entry_t ent, input logic [VPPN_W-1:0] vppn);
    if (ent.ps == PS_4M) return ent.vppn[18:9] == vppn[18:9];
    return ent.vppn == vppn;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational lookup for one search port: per-entry match, lowest-index priority
// encode and even/odd half selection. Results are registered by the top.
module tlb_match
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  tlb_entry_t          ent_i [TLBNUM],
  input  logic [VPPN_W-1:0]   vppn_i,
  input  logic                va_bit12_i,
  input  logic [ASID_W-1:0]   asid_i,
  output logic                found_o,
  output logic [IDXW-1:0]     index_o,
  output logic [PS_W-1:0]     ps_o,
  output logic [LO_W-1:0]     lo_o
);

  logic [TLBNUM-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      hit[i] = ent_i[i].e && (ent_i[i].g || (ent_i[i].asid == asid_i)) && va_match(ent_i[i], vppn_i);
    end
  end

  // Walk from the top down so the lowest matching index is the last one assigned.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    ps_o    = '0;
    lo_o    = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found_o = 1'b1;
        index_o = IDXW'(i);
        ps_o    = ent_i[i].ps;
        lo_o    = ((ent_i[i].ps == PS_4M) ? vppn_i[8] : va_bit12_i) ? ent_i[i].lo1 : ent_i[i].lo0;
      end
    end
  end

endmodule

// File: rtl/tlb_multiport.sv
// Fully-associative TLB with NPORT registered search ports, one write port, one
// combinational read port and single-cycle invtlb. Macro TLB_LFSR_FILL_EN selects LFSR fill.
module tlb_multiport
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM),
  parameter int NPORT  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORT-1:0]         s_req,
  input  logic [NPORT*VPPN_W-1:0]  s_vppn,
  input  logic [NPORT-1:0]         s_va_bit12,
  input  logic [NPORT*ASID_W-1:0]  s_asid,
  output logic [NPORT-1:0]         s_rsp_valid,
  output logic [NPORT-1:0]         s_found,
  output logic [NPORT*IDXW-1:0]    s_index,
  output logic [NPORT*PS_W-1:0]    s_ps,
  output logic [NPORT*LO_W-1:0]    s_lo,
  input  logic                     we,
  input  logic                     w_fill,
  input  logic [IDXW-1:0]          w_index,
  input  logic                     w_e,
  input  logic                     w_g,
  input  logic [VPPN_W-1:0]        w_vppn,
  input  logic [PS_W-1:0]          w_ps,
  input  logic [ASID_W-1:0]        w_asid,
  input  logic [LO_W-1:0]          w_lo0,
  input  logic [LO_W-1:0]          w_lo1,
  output logic [IDXW-1:0]          fill_index,
  input  logic [IDXW-1:0]          r_index,
  output logic                     r_e,
  output logic                     r_g,
  output logic [VPPN_W-1:0]        r_vppn,
  output logic [PS_W-1:0]          r_ps,
  output logic [ASID_W-1:0]        r_asid,
  output logic [LO_W-1:0]          r_lo0,
  output logic [LO_W-1:0]          r_lo1,
  input  logic                     inv_valid,
  input  logic [4:0]               inv_op,
  input  logic [ASID_W-1:0]        inv_asid,
  input  logic [VPPN_W-1:0]        inv_vppn,
  output logic                     inv_ill
);

  tlb_entry_t entries_q [TLBNUM];
  tlb_entry_t entries_d [TLBNUM];

  logic [IDXW-1:0] wr_idx;
  logic            inv_ill_q, inv_ill_d;

  // ---------------- search ports ----------------
  logic            m_found [NPORT];
  logic [IDXW-1:0] m_index [NPORT];
  logic [PS_W-1:0] m_ps    [NPORT];
  logic [LO_W-1:0] m_lo    [NPORT];

  logic [NPORT-1:0] rsp_valid_q;
  logic [NPORT-1:0] found_q;
  logic [IDXW-1:0]  index_q [NPORT];
  logic [PS_W-1:0]  ps_q    [NPORT];
  logic [LO_W-1:0]  lo_q    [NPORT];

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_match (
      .ent_i      (entries_q),
      .vppn_i     (s_vppn[p*VPPN_W +: VPPN_W]),
      .va_bit12_i (s_va_bit12[p]),
      .asid_i     (s_asid[p*ASID_W +: ASID_W]),
      .found_o    (m_found[p]),
      .index_o    (m_index[p]),
      .ps_o       (m_ps[p]),
      .lo_o       (m_lo[p])
    );

    assign s_index[p*IDXW +: IDXW] = index_q[p];
    assign s_ps[p*PS_W +: PS_W]    = ps_q[p];
    assign s_lo[p*LO_W +: LO_W]    = lo_q[p];
  end

  assign s_rsp_valid = rsp_valid_q;
  assign s_found     = found_q;

  // Matchers look at entries_q, so a same-edge write or invtlb is not yet visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= '0;
      found_q     <= '0;
      for (int p = 0; p < NPORT; p++) begin
        index_q[p] <= '0;
        ps_q[p]    <= '0;
        lo_q[p]    <= '0;
      end
    end else begin
      rsp_valid_q <= s_req;
      for (int p = 0; p < NPORT; p++) begin
        if (s_req[p]) begin
          found_q[p] <= m_found[p];
          index_q[p] <= m_index[p];
          ps_q[p]    <= m_ps[p];
          lo_q[p]    <= m_lo[p];
        end
      end
    end
  end

  // ---------------- fill index ----------------
`ifdef TLB_LFSR_FILL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign fill_index = lfsr_q[IDXW-1:0];

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  logic [IDXW-1:0] rr_q, rr_d;

  assign rr_d       = (we && w_fill) ? rr_q + 1'b1 : rr_q;
  assign fill_index = rr_q;

  always_ff @(posedge clk) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`endif

  // ---------------- write / invtlb ----------------
  assign wr_idx = w_fill ? fill_index : w_index;

  // Invalidate is applied first so a same-edge write always survives on its index.
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      entries_d[i] = entries_q[i];
    end
    inv_ill_d = inv_valid && (inv_op > INVTLB_OP_GASID_VA);
    if (inv_valid) begin
      for (int i = 0; i < TLBNUM; i++) begin
        unique case (inv_op)
          INVTLB_OP_ALL0, INVTLB_OP_ALL1: entries_d[i].e = 1'b0;
          INVTLB_OP_G1: if (entries_q[i].g) entries_d[i].e = 1'b0;
          INVTLB_OP_G0: if (!entries_q[i].g) entries_d[i].e = 1'b0;
          INVTLB_OP_ASID:
            if (!entries_q[i].g && entries_q[i].asid == inv_asid) entries_d[i].e = 1'b0;
          INVTLB_OP_ASID_VA:
            if (!entries_q[i].g && entries_q[i].asid == inv_asid && va_match(entries_q[i], inv_vppn))
              entries_d[i].e = 1'b0;
          INVTLB_OP_GASID_VA:
            if ((entries_q[i].g || entries_q[i].asid == inv_asid) && va_match(entries_q[i], inv_vppn))
              entries_d[i].e = 1'b0;
          default: ;
        endcase
      end
    end
    if (we) begin
      entries_d[wr_idx] = '{e: w_e, g: w_g, vppn: w_vppn, ps: w_ps, asid: w_asid,
                            lo0: w_lo0, lo1: w_lo1};
    end
  end

  // Reset only clears the exist bits; other fields keep their last written value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        entries_q[i].e <= 1'b0;
      end
      inv_ill_q <= 1'b0;
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        entries_q[i] <= entries_d[i];
      end
      inv_ill_q <= inv_ill_d;
    end
  end

  assign inv_ill = inv_ill_q;

  // ---------------- read port ----------------
  assign r_e    = entries_q[r_index].e;
  assign r_g    = entries_q[r_index].g;
  assign r_vppn = entries_q[r_index].vppn;
  assign r_ps   = entries_q[r_index].ps;
  assign r_asid = entries_q[r_index].asid;
  assign r_lo0  = entries_q[r_index].lo0;
  assign r_lo1  = entries_q[r_index].lo1;

endmodule
